// File: rtl/icebreaker_7sd_pkg.sv
// icebreaker_7sd_pkg: shared state encoding, blank pattern and hex-to-segment map.
package icebreaker_7sd_pkg;
  typedef enum logic [1:0] {ST_OFF, ST_BLANK, ST_LIT} state_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] HEX7_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    return HEX7_LUT[nib];
  endfunction
endpackage

// File: rtl/icebreaker_7sd_decode.sv
// icebreaker_7sd_decode: one digit slot to active-low segments, hex nibble or raw.
module icebreaker_7sd_decode
  import icebreaker_7sd_pkg::*;
(
  input  logic [6:0] i_slot,
  input  logic       i_hex,
  output logic [6:0] o_seg
);
  always_comb o_seg = i_hex ? hex7(i_slot[3:0]) : i_slot;
endmodule

// File: rtl/icebreaker_7sd_mux.sv
// icebreaker_7sd_mux: multiplexed 7-segment driver with dead-time, PWM dimming and frame-synchronous shadow data.
module icebreaker_7sd_mux
  import icebreaker_7sd_pkg::*;
#(
  parameter int NDIGITS  = 2,
  parameter int PERIOD_W = 16,
  parameter int DEAD     = 64,
  parameter int BRIGHT_W = 3,
  parameter int SEL_W    = $clog2(NDIGITS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 hex_en,
  input  logic [NDIGITS*7-1:0] data,
  input  logic                 load,
  output logic                 load_ack,
  input  logic [BRIGHT_W-1:0]  bright,
  output logic [6:0]           disp,
  output logic [SEL_W-1:0]     sel,
  output logic                 frame
);
  localparam logic [PERIOD_W-1:0] DEAD_T = PERIOD_W'(DEAD);
  localparam logic [SEL_W-1:0]    LAST   = SEL_W'(NDIGITS - 1);
  state_t              r_state, w_state_nx;
  logic [PERIOD_W-1:0] r_timer, w_timer_nx;
  logic [6:0]          r_shadow [NDIGITS];
  logic                r_hex;
  logic                w_slot_end, w_boundary, w_swap, w_lit;
  logic [6:0]          w_seg;
  icebreaker_7sd_decode u_decode (.i_slot(r_shadow[sel]), .i_hex(r_hex), .o_seg(w_seg));
  always_comb begin
    w_slot_end = r_state != ST_OFF && r_timer == '1;
    w_boundary = w_slot_end && sel == LAST;
    w_swap     = load && (r_state == ST_OFF || (en && w_boundary));
    w_lit      = en && r_state == ST_LIT && r_timer[PERIOD_W-1 -: BRIGHT_W] < bright;
    w_timer_nx = (!en || r_state == ST_OFF) ? '0 : r_timer + 1'b1;
    // LIT covers every timer value at or past the dead-time, so a wrap lands in BLANK
    w_state_nx = !en ? ST_OFF : (w_timer_nx >= DEAD_T) ? ST_LIT : ST_BLANK;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_OFF;
      r_timer  <= '0;
      sel      <= '0;
      frame    <= 1'b0;
      disp     <= SEG_BLANK;
      load_ack <= 1'b0;
      r_hex    <= 1'b0;
      for (int d = 0; d < NDIGITS; d++) r_shadow[d] <= '1;
    end else begin
      r_state  <= w_state_nx;
      r_timer  <= w_timer_nx;
      sel      <= (!en || r_state == ST_OFF) ? '0 : w_slot_end ? (sel == LAST ? '0 : sel + 1'b1) : sel;
      frame    <= en && (r_state == ST_OFF || w_boundary);
      disp     <= w_lit ? w_seg : SEG_BLANK;
      load_ack <= w_swap;
      if (w_swap) begin
        r_hex <= hex_en;
        for (int d = 0; d < NDIGITS; d++) r_shadow[d] <= data[7*d +: 7];
      end
    end
  end
endmodule

// File: tb/tb_icebreaker_7sd_mux.sv
// tb_icebreaker_7sd_mux: randomized directed scenarios checked every cycle against a slot-position reference model.
module tb_icebreaker_7sd_mux;
  localparam int ND = 3, PW = 4, DT = 2, BW = 2;
  localparam int SLOT = 1 << PW;
  logic          clk = 0, rst = 1, en = 0, hex_en = 0, load = 0;
  logic [ND*7-1:0] data = '0;
  logic [BW-1:0] bright = '0;
  logic          load_ack, frame;
  logic [6:0]    disp;
  logic [1:0]    sel;
  int checks = 0, errors = 0;
  bit         m_run = 0;
  int         m_k = 0;
  logic [6:0] m_sh [ND];
  logic       m_hex = 0;
  logic [6:0] e_disp;
  logic [1:0] e_sel;
  logic       e_frame, e_ack;
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  icebreaker_7sd_mux #(.NDIGITS(ND), .PERIOD_W(PW), .DEAD(DT), .BRIGHT_W(BW)) dut (
    .clk(clk), .rst(rst), .en(en), .hex_en(hex_en), .data(data), .load(load),
    .load_ack(load_ack), .bright(bright), .disp(disp), .sel(sel), .frame(frame));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: position in the running sequence is a plain cycle count since enable.
  task automatic cyc();
    int t, s;
    bit boundary, swap;
    logic [6:0] slot;
    t = m_k % SLOT;
    s = (m_k / SLOT) % ND;
    if (rst) begin
      m_run = 0; m_k = 0; m_hex = 0;
      for (int d = 0; d < ND; d++) m_sh[d] = 7'h7F;
      e_disp = 7'h7F; e_sel = 0; e_frame = 0; e_ack = 0;
    end else begin
      slot = m_sh[s];
      e_disp = (en && m_run && t >= DT && (t / (SLOT >> BW)) < int'(bright))
             ? (m_hex ? hex_tab[slot[3:0]] : slot) : 7'h7F;
      boundary = m_run && t == SLOT - 1 && s == ND - 1;
      swap = load && (!m_run || (en && boundary));
      e_ack = swap;
      e_frame = en && (!m_run || boundary);
      if (swap) begin
        m_hex = hex_en;
        for (int d = 0; d < ND; d++) m_sh[d] = data[7*d +: 7];
      end
      if (!en) begin m_run = 0; m_k = 0; end
      else if (!m_run) begin m_run = 1; m_k = 0; end
      else m_k++;
      e_sel = m_run ? 2'((m_k / SLOT) % ND) : 2'd0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("disp", 32'(disp), 32'(e_disp));
    chk("sel", 32'(sel), 32'(e_sel));
    chk("frame", 32'(frame), 32'(e_frame));
    chk("load_ack", 32'(load_ack), 32'(e_ack));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_load(input logic [ND*7-1:0] d, input logic h);
    bit got;
    got = 0;
    data = d; hex_en = h; load = 1;
    for (int i = 0; i < 200 && !got; i++) begin
      cyc();
      got = load_ack;
    end
    load = 0;
    chk("load_handshake", 32'(got), 32'd1);
  endtask

  task automatic wait_pos(input int slot_idx, input int tmr);
    bit hit;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      hit = m_run && (m_k / SLOT) % ND == slot_idx && m_k % SLOT == tmr;
      if (!hit) cyc();
    end
    chk("wait_position", 32'(hit), 32'd1);
  endtask

  initial begin
    @(negedge clk);
    rst = 1; run(3);
    rst = 0; run(4);
    do_load(21'($urandom), 1'b0);
    run(2);
    do_load({7'h02, 7'h01, 7'h00}, 1'b1);
    bright = 3; en = 1;
    run(3 * ND * SLOT + 5);
    bright = 1; run(ND * SLOT);
    bright = 0; run(ND * SLOT);
    bright = 3;
    wait_pos(1, 5);
    do_load({7'h0F, 7'h0A, 7'h08}, 1'b1);
    run(ND * SLOT);
    wait_pos(1, 3);
    do_load({7'h7F, 7'h7F, 7'b0110110}, 1'b0);
    run(ND * SLOT);
    for (int r = 0; r < 6; r++) begin
      bright = 2'($urandom_range(0, 3));
      do_load(21'($urandom), 1'($urandom));
      run($urandom_range(10, 40));
    end
    bright = 3;
    wait_pos(1, 7);
    en = 0; run(3);
    en = 1; run(ND * SLOT + 4);
    wait_pos(2, SLOT - 1);
    en = 0; data = 21'($urandom); hex_en = 1; load = 1;
    cyc(); cyc();
    load = 0; run(2);
    en = 1; run(20);
    data = 21'($urandom); load = 1; rst = 1;
    cyc();
    rst = 0; load = 0; run(3);
    en = 1; run(ND * SLOT);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/icebreaker_7sd_mux.md
# icebreaker_7sd_mux

Parametrised multi-digit 7-segment display controller for icebreaker_lite PMOD-style displays. It time-multiplexes `NDIGITS` digits over one shared active-low segment bus and decodes hex nibbles or passes raw segments. It inserts a blanking dead-time at every digit switch to kill ghosting, and dims via per-slot PWM. Digit data is double-buffered and swapped only at frame boundaries, so a host never produces a torn frame.

## Interface
- `NDIGITS`, 2: digits multiplexed, ≥2.
- `PERIOD_W`, 16: slot length is 2**PERIOD_W clk cycles, 2.7 ms at 24 MHz.
- `DEAD`, 64: blank cycles at the start of each slot, < 2**(PERIOD_W-1).
- `BRIGHT_W`, 3: brightness control width.
- `SEL_W`, $clog2(NDIGITS): digit index width (derived).

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  display enable; 0 blanks and parks.
- `hex_en`  in  1  1: each 7-bit slot's [3:0] is a hex nibble; 0: raw active-low segments.
- `data`  in  NDIGITS*7  digit d occupies [7d+6:7d].
- `load`  in  1  request to latch `data`/`hex_en` into shadow; hold until ack.
- `load_ack`  out  1  one-cycle pulse when shadow was updated.
- `bright`  in  BRIGHT_W  lit fraction per slot; 0 = dark.
- `disp`  out  7  segments, active-low {G,F,E,D,C,B,A}.
- `sel`  out  SEL_W  active digit index.
- `frame`  out  1  one-cycle pulse at the start of digit 0's slot.

## Operation
- FSM states: OFF, BLANK, LIT.
  - OFF: entered on `rst` or `en`=0.
  - OFF→BLANK: when `en`=1; timer=0, sel=0.
  - BLANK→LIT: when timer==DEAD.
  - LIT→BLANK: on timer wrap (advance sel).
  - Any→OFF: when `en`=0, effective the next edge.
- Timer: PERIOD_W-bit free count in BLANK/LIT, held at 0 in OFF.
- Slot end: timer == 2**PERIOD_W-1. At slot end, sel ← sel+1, wrapping NDIGITS-1→0. Non-power-of-2 NDIGITS must wrap correctly.
- Segment output:
  - In LIT, `disp` = seg(d) when timer[PERIOD_W-1 -: BRIGHT_W] < `bright`, else 7'h7F.
  - In BLANK and OFF, `disp` = 7'h7F.
- Decode: seg(d) = hex7(shadow[d][3:0]) if shadow_hex, else shadow[d].
  - hex7 is the standard active-low map: 0→7'b1000000, 1→7'b1111001, 8→7'b0000000, A→7'b0001000, F→7'b0001110.
- Shadow swap:
  - Occurs when `load`=1 at a frame boundary (slot end with sel==NDIGITS-1), or on any cycle while in OFF.
  - Shadow ← {`data`,`hex_en`}; `load_ack`=1 the following cycle.
  - `load` held across many frames gets one ack per frame boundary. The host drops `load` on ack.
- `bright` is sampled live; it is not shadowed.

## Timing
- Reset values:
  - `disp`=7'h7F, `sel`=0, `load_ack`=0, `frame`=0, state OFF, timer 0.
  - Shadow = all 1s (raw blank), shadow_hex=0.
- All outputs are registered; `disp` lags the state/timer decision by one clk.
- `frame` asserts in the same cycle `sel` first becomes 0 in BLANK, including the first cycle after OFF→BLANK.
- `rst` mid-frame: reset values on the next edge. Any pending load is dropped with no ack.
- `en` falls and `load` is asserted in the same cycle: enter OFF, then ack in OFF on the next cycle.
- Frame boundary coinciding with `en`=0: `en` wins (OFF). The load is serviced in OFF.
- `bright`=2**BRIGHT_W-1: lit to the last 1/2**BRIGHT_W of the slot. Dead-time always overrides.

## Structure
- Package `icebreaker_7sd_pkg`:
  - state enum.
  - `SEG_BLANK`=7'h7F.
  - 16-entry hex-to-segment constant array and function `hex7()`.
- Sub-module `icebreaker_7sd_decode`: combinational nibble/raw→segment, instanced once on the selected shadow slot.
- Top holds the FSM, timer, sel counter, shadow registers and load handshake.

## Test plan
All scenarios use NDIGITS=3, PERIOD_W=4, DEAD=2, BRIGHT_W=2.
- Reset/idle: `rst`=1 for 3 cycles, then `en`=0 → `disp`=7'h7F, `sel`=0, no `frame`; `load`=1 → `load_ack` 1 cycle later, shadow = `data`.
- Scan: `en`=1, `hex_en`=1, `data`={4'h2,4'h1,4'h0} slots, `bright`=3 → sel sequence 0,1,2,0 every 16 cycles. Per slot, `disp`=7'h7F for 2 cycles, then 7'b1000000/7'b1111001/7'b0100100 until timer 12. `frame` every 48 cycles.
- PWM: `bright`=1 → lit only for timer 2..3; `bright`=0 → `disp` constant 7'h7F.
- Load tearing: raise `load` with new data mid-slot 1 → old segments until the sel 2→0 edge; ack exactly at that boundary; new digits from slot 0.
- Raw mode: `hex_en`=0, slot 0=7'b0110110 → `disp`=7'b0110110 in LIT.
- Mid-op reset/disable: drop `en` at timer 7 of slot 1 → next edge `disp`=7'h7F, `sel`=0. Re-enable → `frame` pulse, slot 0 restarts.
